// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: two-flop synchroniser, symmetric stability
// filter, press/release strobes and optional hold-to-repeat strobe train.
module multi_debouncer #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned STABLE_COUNT = 16777215,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned HOLD_W       = 28,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STABLE_COUNT - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  // Phase of the hold counter: waiting for the first repeat, or in the repeat train.
  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } phase_e;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  // Two-flop synchroniser on the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Any sample agreeing with the current level discards all accumulated credit.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (sync2_q[ch] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync2_q[ch];
          press_d = sync2_q[ch];
          rel_d   = ~sync2_q[ch];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign level[ch]         = level_q;
    assign press[ch]         = press_q;
    assign release_pulse[ch] = rel_q;

    if (REPEAT_EN) begin : g_hold
      logic [HOLD_W-1:0] hold_q;
      logic [HOLD_W-1:0] hold_d;
      phase_e            phase_q;
      phase_e            phase_d;
      logic              rpt_q;
      logic              rpt_d;

      always_ff @(posedge clk) begin
        if (reset) begin
          hold_q  <= '0;
          phase_q <= PH_DELAY;
          rpt_q   <= 1'b0;
        end else begin
          hold_q  <= hold_d;
          phase_q <= phase_d;
          rpt_q   <= rpt_d;
        end
      end

      // Counting only while held and not falling this cycle, so a repeat
      // coinciding with the release edge is dropped.
      always_comb begin
        hold_d  = '0;
        phase_d = PH_DELAY;
        rpt_d   = 1'b0;
        if (level_q && level_d) begin
          hold_d  = hold_q + HOLD_W'(1);
          phase_d = phase_q;
          case (phase_q)
            PH_DELAY: begin
              if (hold_q == DELAY_LAST) begin
                rpt_d   = 1'b1;
                hold_d  = '0;
                phase_d = PH_RATE;
              end
            end
            PH_RATE: begin
              if (hold_q == RATE_LAST) begin
                rpt_d  = 1'b1;
                hold_d = '0;
              end
            end
            default: begin
              phase_d = PH_DELAY;
              hold_d  = '0;
            end
          endcase
        end
      end

      assign repeat_pulse[ch] = rpt_q;
    end else begin : g_no_hold
      assign repeat_pulse[ch] = 1'b0;
    end

    property p_no_press_and_release;
      @(posedge clk) disable iff (reset) !(press_q && rel_q);
    endproperty
    a_no_press_and_release: assert property (p_no_press_and_release);
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares, and flags any stray pulse.
module tb_multi_debouncer;

  localparam int unsigned CH = 2;

  logic          clk;
  logic          reset;
  logic [CH-1:0] button;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] repeat_pulse;

  multi_debouncer #(
    .CHANNELS    (CH),
    .CNT_W       (4),
    .STABLE_COUNT(4),
    .REPEAT_EN   (1'b1),
    .HOLD_W      (5),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  typedef struct {
    int            c;
    logic [CH-1:0] p;
    logic [CH-1:0] r;
    logic [CH-1:0] t;
    logic [CH-1:0] l;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int c, input logic [CH-1:0] p, input logic [CH-1:0] r,
                                    input logic [CH-1:0] t, input logic [CH-1:0] l);
    exp_t e;
    e.c = c; e.p = p; e.r = r; e.t = t; e.l = l;
    exp_q.push_back(e);
  endfunction

  // Monitor: outputs are stable at the falling edge, cyc equals edges seen so far.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        checks++;
        $display("FAIL missed_entry cyc=%0d expected p=%b r=%b t=%b l=%b never compared",
                 exp_q[0].c, exp_q[0].p, exp_q[0].r, exp_q[0].t, exp_q[0].l);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (press === e.p && release_pulse === e.r && repeat_pulse === e.t && level === e.l)
          passes++;
        else
          $display("FAIL outputs cyc=%0d got p=%b r=%b t=%b l=%b expected p=%b r=%b t=%b l=%b",
                   cyc, press, release_pulse, repeat_pulse, level, e.p, e.r, e.t, e.l);
      end else if ((press | release_pulse | repeat_pulse) !== '0) begin
        checks++;
        $display("FAIL stray_pulse cyc=%0d got p=%b r=%b t=%b l=%b expected no pulse",
                 cyc, press, release_pulse, repeat_pulse, level);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  initial begin
    // Reset with both buttons held: new press after full latency from edge 4.
    reset  = 1'b1;
    button = 2'b11;
    expect_at(1, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(2, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(3, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(8, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(9, 2'b11, 2'b00, 2'b00, 2'b11);
    expect_at(10, 2'b00, 2'b00, 2'b00, 2'b11);
    expect_at(16, 2'b00, 2'b11, 2'b00, 2'b00);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);
    button = 2'b00;

    // ch0 clean press at 30, glitch at 52-53, drop at 61 (release lands on a due repeat).
    wait_cyc(29);
    button[0] = 1'b1;
    expect_at(30, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(35, 2'b01, 2'b00, 2'b00, 2'b01);
    expect_at(45, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(48, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(51, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(54, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(55, 2'b00, 2'b00, 2'b00, 2'b01);
    expect_at(57, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(60, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(63, 2'b00, 2'b00, 2'b01, 2'b01);
    expect_at(66, 2'b00, 2'b01, 2'b00, 2'b00);
    expect_at(67, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(70, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_cyc(51);
    button[0] = 1'b0;
    wait_cyc(53);
    button[0] = 1'b1;
    wait_cyc(60);
    button[0] = 1'b0;

    // ch1 bounce: 1,1,1,0 then steady 1 from edge 84.
    wait_cyc(79);
    button[1] = 1'b1;
    expect_at(85, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(89, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_at(95, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_cyc(82);
    button[1] = 1'b0;
    wait_cyc(83);
    button[1] = 1'b1;
    wait_cyc(89);
    button[1] = 1'b0;

    // Both pressed together; ch0 released mid-train; reset mid-count and mid-hold.
    wait_cyc(109);
    button = 2'b11;
    expect_at(115, 2'b11, 2'b00, 2'b00, 2'b11);
    expect_at(125, 2'b00, 2'b00, 2'b11, 2'b11);
    expect_at(128, 2'b00, 2'b00, 2'b11, 2'b11);
    expect_at(131, 2'b00, 2'b01, 2'b10, 2'b10);
    expect_at(134, 2'b00, 2'b00, 2'b10, 2'b10);
    expect_at(137, 2'b00, 2'b00, 2'b10, 2'b10);
    expect_at(140, 2'b00, 2'b00, 2'b10, 2'b10);
    expect_at(142, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(143, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(147, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(148, 2'b11, 2'b00, 2'b00, 2'b11);
    expect_at(155, 2'b00, 2'b11, 2'b00, 2'b00);
    expect_at(160, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_cyc(125);
    button[0] = 1'b0;
    wait_cyc(137);
    button[0] = 1'b1;
    wait_cyc(141);
    reset = 1'b1;
    wait_cyc(142);
    reset = 1'b0;
    wait_cyc(149);
    button = 2'b00;

    wait_cyc(165);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL leftover_entries got %0d unchecked expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel push-button debouncer with an input synchroniser, symmetric press/release filtering and optional hold-to-repeat. Each channel outputs a clean level, one-cycle press and release strobes, and a repeat strobe train while the button is held. It sits between raw board buttons/switches and counter/display control logic, and replaces per-button single-channel debouncers.

Parameters:
CHANNELS, 4, number of independent button channels
CNT_W, 24, width of each per-channel stability counter
STABLE_COUNT, 16777215, consecutive sampled cycles the input must differ from level before level flips; 1 <= STABLE_COUNT <= 2^CNT_W-1
REPEAT_EN, 1, 1 = generate repeat strobes while held; 0 = repeat tied low, hold logic removed
HOLD_W, 28, width of each per-channel hold counter
REPEAT_DELAY, 50000000, cycles of level=1 before first repeat strobe; 1 <= value <= 2^HOLD_W-1
REPEAT_RATE, 10000000, cycles between subsequent repeat strobes; 1 <= value <= 2^HOLD_W-1

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high; clears all state
button  input  CHANNELS  raw asynchronous button inputs, active-high
level  output  CHANNELS  debounced button state
press  output  CHANNELS  one-cycle pulse on debounced 0->1
release  output  CHANNELS  one-cycle pulse on debounced 1->0
repeat  output  CHANNELS  one-cycle auto-repeat pulses while held (REPEAT_EN=1)

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered.
- Reset: sync flops, counters, level, press, release, repeat, repeat phase all 0, per channel. Reset takes priority over all other activity, including mid-count or mid-hold.
- Synchroniser: 2 flops per channel (s1, s2). Filter logic sees s2 only.
- Stability filter, per channel, each cycle:
  - s2 == level: cnt <= 0.
  - s2 != level, cnt < STABLE_COUNT-1: cnt <= cnt+1.
  - s2 != level, cnt == STABLE_COUNT-1: level <= s2, cnt <= 0, and press <= s2 or release <= ~s2 for exactly that one cycle.
- Latency: raw change first sampled at edge N means level changes at edge N+STABLE_COUNT+1. Bounces shorter than this restart cnt at 0. No partial credit is kept.
- press/release are 0 on every cycle without a level change. They never assert together on one channel.
- Hold/repeat, per channel, REPEAT_EN=1:
  - While level=0: hold_cnt=0, phase=0, repeat=0.
  - While level=1 and phase=0: hold_cnt increments. When hold_cnt == REPEAT_DELAY-1: repeat pulses 1 cycle, hold_cnt <= 0, phase <= 1.
  - While level=1 and phase=1: hold_cnt increments. When hold_cnt == REPEAT_RATE-1: repeat pulses, hold_cnt <= 0.
  - The hold counter starts on the first cycle level=1, the cycle after press.
  - The cycle level falls (release), hold_cnt and phase clear. A repeat due on that cycle is suppressed.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Button held through reset deassertion: treated as a new press. press fires after the full filter latency.
- Counters never wrap: cnt is bounded by STABLE_COUNT-1 and hold_cnt by max(REPEAT_DELAY, REPEAT_RATE)-1.

Test Plan:
- Params CHANNELS=2, STABLE_COUNT=4, REPEAT_DELAY=10, REPEAT_RATE=3. Reset 3 cycles with button=2'b11 -> all outputs 0 during reset; after release, level[0] rises 5 edges after first sample, press[0] one cycle.
- Clean press on ch0 at edge 0, held -> level[0]=1 after edge 5, press[0] at edge 5 only, repeat[0] at edges 15, 18, 21, ...
- Bounce ch1: 1 for 3 cycles, 0 for 1, then 1 steady from edge 4 -> no press during bounce; level[1] rises at edge 9.
- Release after hold: drop button[0] at edge 30 -> release[0] pulse at edge 35, level[0]=0; no repeat at or after edge 35; a 2-cycle low glitch while held produces no release.
- Simultaneous: both channels pressed same edge -> press=2'b11 on the same cycle; ch0 released while ch1 held -> ch1 repeat cadence unaffected.
- Reset asserted mid-count (cnt=2) and mid-hold (phase=1) -> next cycle all state 0; no spurious press, release or repeat on the reset cycle.
